// File: rtl/calc_pkg.sv
// Shared command codes, response codes and port FSM encodings for calc_arb.
package calc_pkg;

    localparam int NUM_PORTS = 4;

    typedef enum logic [3:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_SHL = 4'd5,
        CMD_SHR = 4'd6
    } cmd_e;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_OK   = 2'd1,
        RESP_ERR  = 2'd2
    } resp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP2  = 2'd1,
        ST_PEND = 2'd2
    } state_e;

endpackage

// File: rtl/calc_alu.sv
// Combinational ALU shared by all requester ports; overflow, underflow and
// unknown commands report an error with zero data.
module calc_alu
    import calc_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [0:3]        cmd_i,
    input  logic [0:DATA_W-1] op1_i,
    input  logic [0:DATA_W-1] op2_i,
    output logic [0:1]        resp_o,
    output logic [0:DATA_W-1] data_o
);

    logic [DATA_W:0] sum;
    logic [4:0]      shamt;

    always_comb begin
        sum    = {1'b0, op1_i} + {1'b0, op2_i};
        shamt  = op2_i[DATA_W-5:DATA_W-1];
        resp_o = RESP_ERR;
        data_o = '0;
        case (cmd_i)
            CMD_ADD: begin
                if (!sum[DATA_W]) begin
                    resp_o = RESP_OK;
                    data_o = sum[DATA_W-1:0];
                end
            end
            CMD_SUB: begin
                if (op2_i <= op1_i) begin
                    resp_o = RESP_OK;
                    data_o = op1_i - op2_i;
                end
            end
            CMD_SHL: begin
                resp_o = RESP_OK;
                data_o = op1_i << shamt;
            end
            CMD_SHR: begin
                resp_o = RESP_OK;
                data_o = op1_i >> shamt;
            end
            default: begin
                resp_o = RESP_ERR;
                data_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/calc_arb.sv
// Four-port round-robin front end to one shared ALU with a registered,
// single-cycle response per granted request.
//   state   | meaning
//   IDLE    | waiting for a non-zero command; captures cmd and operand 1
//   OP2     | captures operand 2 this cycle
//   PEND    | waiting for the arbiter; result is registered on grant
module calc_arb
    import calc_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              c_clk,
    input  logic              reset_n,
    input  logic [0:3]        req1_cmd_in,
    input  logic [0:3]        req2_cmd_in,
    input  logic [0:3]        req3_cmd_in,
    input  logic [0:3]        req4_cmd_in,
    input  logic [0:DATA_W-1] req1_data_in,
    input  logic [0:DATA_W-1] req2_data_in,
    input  logic [0:DATA_W-1] req3_data_in,
    input  logic [0:DATA_W-1] req4_data_in,
    output logic [0:1]        out_resp1,
    output logic [0:1]        out_resp2,
    output logic [0:1]        out_resp3,
    output logic [0:1]        out_resp4,
    output logic [0:DATA_W-1] out_data1,
    output logic [0:DATA_W-1] out_data2,
    output logic [0:DATA_W-1] out_data3,
    output logic [0:DATA_W-1] out_data4
);

    logic [0:3]        cmd_in  [NUM_PORTS];
    logic [0:DATA_W-1] data_in [NUM_PORTS];

    state_e            state_q [NUM_PORTS];
    logic [0:3]        cmd_q   [NUM_PORTS];
    logic [0:DATA_W-1] op1_q   [NUM_PORTS];
    logic [0:DATA_W-1] op2_q   [NUM_PORTS];
    logic [0:1]        resp_q  [NUM_PORTS];
    logic [0:DATA_W-1] data_q  [NUM_PORTS];
    logic [1:0]        ptr_q, ptr_d;

    logic              gnt_vld;
    logic [1:0]        gnt_idx;
    logic [1:0]        cand;
    logic [0:1]        alu_resp;
    logic [0:DATA_W-1] alu_data;

    assign cmd_in  = '{req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in};
    assign data_in = '{req1_data_in, req2_data_in, req3_data_in, req4_data_in};

    // Search starts at the pointer and wraps, so the first PEND port found wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = ptr_q;
        cand    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = ptr_q + 2'(i);
            if (!gnt_vld && state_q[cand] == ST_PEND) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        ptr_d = gnt_vld ? gnt_idx + 2'd1 : ptr_q;
    end

    calc_alu #(.DATA_W(DATA_W)) u_alu (
        .cmd_i  (cmd_q[gnt_idx]),
        .op1_i  (op1_q[gnt_idx]),
        .op2_i  (op2_q[gnt_idx]),
        .resp_o (alu_resp),
        .data_o (alu_data)
    );

    always_ff @(posedge c_clk) begin
        if (!reset_n) begin
            ptr_q <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                state_q[i] <= ST_IDLE;
                cmd_q[i]   <= '0;
                op1_q[i]   <= '0;
                op2_q[i]   <= '0;
                resp_q[i]  <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            for (int i = 0; i < NUM_PORTS; i++) begin
                resp_q[i] <= '0;
                data_q[i] <= '0;
                case (state_q[i])
                    ST_IDLE: begin
                        if (cmd_in[i] != '0) begin
                            state_q[i] <= ST_OP2;
                            cmd_q[i]   <= cmd_in[i];
                            op1_q[i]   <= data_in[i];
                        end
                    end
                    ST_OP2: begin
                        state_q[i] <= ST_PEND;
                        op2_q[i]   <= data_in[i];
                    end
                    ST_PEND: begin
                        if (gnt_vld && gnt_idx == 2'(i)) begin
                            state_q[i] <= ST_IDLE;
                            resp_q[i]  <= alu_resp;
                            data_q[i]  <= alu_data;
                        end
                    end
                    default: state_q[i] <= ST_IDLE;
                endcase
            end
        end
    end

    assign out_resp1 = resp_q[0];
    assign out_resp2 = resp_q[1];
    assign out_resp3 = resp_q[2];
    assign out_resp4 = resp_q[3];
    assign out_data1 = data_q[0];
    assign out_data2 = data_q[1];
    assign out_data3 = data_q[2];
    assign out_data4 = data_q[3];

endmodule

// File: tb/tb_calc_arb.sv
// Directed bench for calc_arb: hand-computed responses checked one cycle
// wide, away from the rising edge.
module tb_calc_arb;

    logic        c_clk = 1'b0;
    logic        reset_n;
    logic [0:3]  rcmd  [4];
    logic [0:31] rdat  [4];
    logic [0:1]  oresp [4];
    logic [0:31] odata [4];

    logic [0:3]  tcmd [4];
    logic [0:31] top1 [4];
    logic [0:31] top2 [4];
    logic [0:1]  er   [4];
    logic [0:31] ed   [4];

    int nvec = 0;
    int nerr = 0;

    always #5 c_clk = ~c_clk;

    calc_arb #(.DATA_W(32)) dut (
        .c_clk        (c_clk),
        .reset_n      (reset_n),
        .req1_cmd_in  (rcmd[0]),
        .req2_cmd_in  (rcmd[1]),
        .req3_cmd_in  (rcmd[2]),
        .req4_cmd_in  (rcmd[3]),
        .req1_data_in (rdat[0]),
        .req2_data_in (rdat[1]),
        .req3_data_in (rdat[2]),
        .req4_data_in (rdat[3]),
        .out_resp1    (oresp[0]),
        .out_resp2    (oresp[1]),
        .out_resp3    (oresp[2]),
        .out_resp4    (oresp[3]),
        .out_data1    (odata[0]),
        .out_data2    (odata[1]),
        .out_data3    (odata[2]),
        .out_data4    (odata[3])
    );

    task automatic step();
        @(posedge c_clk);
        @(negedge c_clk);
    endtask

    // Drives cmd+op1 then op2 on every port in mask; returns at the negedge
    // after the op2 edge (T+1), so the next step() lands on the T+3 sample.
    task automatic launch(input logic [3:0] mask);
        for (int i = 0; i < 4; i++)
            if (mask[i]) begin rcmd[i] = tcmd[i]; rdat[i] = top1[i]; end
        step();
        for (int i = 0; i < 4; i++)
            if (mask[i]) begin rcmd[i] = 4'd0; rdat[i] = top2[i]; end
        step();
        for (int i = 0; i < 4; i++) rdat[i] = 32'd0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin rcmd[i] = 4'd0; rdat[i] = 32'd0; end
        repeat (3) step();
        for (int p = 0; p < 4; p++) begin
            nvec++;
            if (oresp[p] !== 2'd0 || odata[p] !== 32'd0) begin
                nerr++;
                $display("FAIL reset p%0d resp=%0d data=%h want resp=0 data=0", p+1, oresp[p], odata[p]);
            end
        end
        reset_n = 1'b1;
    endtask

    task automatic test_all_four();
        for (int rnd = 0; rnd < 2; rnd++) begin
            for (int i = 0; i < 4; i++) begin
                tcmd[i] = 4'd1; top1[i] = 32'd5; top2[i] = 32'(i + 1);
            end
            launch(4'b1111);
            for (int k = 0; k < 4; k++) begin
                step();
                for (int p = 0; p < 4; p++) begin
                    er[p] = (p == k) ? 2'd1 : 2'd0;
                    ed[p] = (p == k) ? 32'(6 + k) : 32'd0;
                    nvec++;
                    if (oresp[p] !== er[p] || odata[p] !== ed[p]) begin
                        nerr++;
                        $display("FAIL all_four rnd%0d slot%0d p%0d resp=%0d data=%h want resp=%0d data=%h",
                                 rnd, k, p+1, oresp[p], odata[p], er[p], ed[p]);
                    end
                end
            end
        end
    endtask

    task automatic test_add();
        tcmd[0] = 4'd1; top1[0] = 32'h0000_0001; top2[0] = 32'h01FF_FFFF;
        launch(4'b0001);
        for (int c = 0; c < 2; c++) begin
            step();
            for (int p = 0; p < 4; p++) begin
                er[p] = (c == 0 && p == 0) ? 2'd1 : 2'd0;
                ed[p] = (c == 0 && p == 0) ? 32'h0200_0000 : 32'd0;
                nvec++;
                if (oresp[p] !== er[p] || odata[p] !== ed[p]) begin
                    nerr++;
                    $display("FAIL add cyc%0d p%0d resp=%0d data=%h want resp=%0d data=%h",
                             c, p+1, oresp[p], odata[p], er[p], ed[p]);
                end
            end
        end
    endtask

    task automatic test_port2_bounds();
        logic [0:3]  vc [5];
        logic [0:31] v1 [5];
        logic [0:31] v2 [5];
        logic [0:1]  vr [5];
        logic [0:31] vd [5];
        vc = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd2};
        v1 = '{32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE, 32'h5, 32'hF};
        v2 = '{32'h1, 32'hF, 32'h1, 32'h5, 32'h1};
        vr = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd1};
        vd = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'hE};
        for (int v = 0; v < 5; v++) begin
            tcmd[1] = vc[v]; top1[1] = v1[v]; top2[1] = v2[v];
            launch(4'b0010);
            step();
            nvec++;
            if (oresp[1] !== vr[v] || odata[1] !== vd[v]) begin
                nerr++;
                $display("FAIL port2 vec%0d resp=%0d data=%h want resp=%0d data=%h",
                         v, oresp[1], odata[1], vr[v], vd[v]);
            end
        end
    endtask

    task automatic test_port3_ops();
        logic [0:3]  vc [4];
        logic [0:31] v1 [4];
        logic [0:31] v2 [4];
        logic [0:1]  vr [4];
        logic [0:31] vd [4];
        vc = '{4'd3, 4'd4, 4'd6, 4'd5};
        v1 = '{32'h1, 32'h1, 32'h8000_0000, 32'h1};
        v2 = '{32'h1, 32'h1, 32'h1F, 32'h24};
        vr = '{2'd2, 2'd2, 2'd1, 2'd1};
        vd = '{32'h0, 32'h0, 32'h1, 32'h10};
        for (int v = 0; v < 4; v++) begin
            tcmd[2] = vc[v]; top1[2] = v1[v]; top2[2] = v2[v];
            launch(4'b0100);
            step();
            nvec++;
            if (oresp[2] !== vr[v] || odata[2] !== vd[v]) begin
                nerr++;
                $display("FAIL port3 vec%0d resp=%0d data=%h want resp=%0d data=%h",
                         v, oresp[2], odata[2], vr[v], vd[v]);
            end
        end
        // shl 1 by 4, with an add held on cmd during the op2 cycle (must be ignored)
        rcmd[2] = 4'd5; rdat[2] = 32'h1;
        step();
        rcmd[2] = 4'd1; rdat[2] = 32'h4;
        step();
        rcmd[2] = 4'd0; rdat[2] = 32'h0;
        step();
        nvec++;
        if (oresp[2] !== 2'd1 || odata[2] !== 32'h10) begin
            nerr++;
            $display("FAIL port3 shl resp=%0d data=%h want resp=1 data=00000010", oresp[2], odata[2]);
        end
        step();
        nvec++;
        if (oresp[2] !== 2'd0 || odata[2] !== 32'h0) begin
            nerr++;
            $display("FAIL port3 ignored_cmd resp=%0d data=%h want resp=0 data=0", oresp[2], odata[2]);
        end
    endtask

    task automatic test_ptr_priority();
        tcmd[3] = 4'd1; top1[3] = 32'd2;  top2[3] = 32'd3;
        tcmd[0] = 4'd1; top1[0] = 32'd10; top2[0] = 32'd20;
        launch(4'b1001);
        for (int c = 0; c < 2; c++) begin
            step();
            for (int p = 0; p < 4; p++) begin
                er[p] = ((c == 0 && p == 3) || (c == 1 && p == 0)) ? 2'd1 : 2'd0;
                ed[p] = (c == 0 && p == 3) ? 32'd5 : ((c == 1 && p == 0) ? 32'd30 : 32'd0);
                nvec++;
                if (oresp[p] !== er[p] || odata[p] !== ed[p]) begin
                    nerr++;
                    $display("FAIL ptr_prio cyc%0d p%0d resp=%0d data=%h want resp=%0d data=%h",
                             c, p+1, oresp[p], odata[p], er[p], ed[p]);
                end
            end
        end
    endtask

    task automatic test_reset_inflight();
        tcmd[0] = 4'd1; top1[0] = 32'd100; top2[0] = 32'd1;
        launch(4'b0001);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        rcmd[1] = 4'd2; rdat[1] = 32'd9;
        for (int c = 0; c < 3; c++) begin
            step();
            if (c == 0) begin rcmd[1] = 4'd0; rdat[1] = 32'd4; end
            if (c == 1) rdat[1] = 32'd0;
            for (int p = 0; p < 4; p++) begin
                er[p] = (c == 2 && p == 1) ? 2'd1 : 2'd0;
                ed[p] = (c == 2 && p == 1) ? 32'd5 : 32'd0;
                nvec++;
                if (oresp[p] !== er[p] || odata[p] !== ed[p]) begin
                    nerr++;
                    $display("FAIL reset_inflight cyc%0d p%0d resp=%0d data=%h want resp=%0d data=%h",
                             c, p+1, oresp[p], odata[p], er[p], ed[p]);
                end
            end
        end
        step();
        nvec++;
        if (oresp[0] !== 2'd0 || oresp[1] !== 2'd0) begin
            nerr++;
            $display("FAIL reset_inflight tail resp1=%0d resp2=%0d want 0 0", oresp[0], oresp[1]);
        end
    endtask

    initial begin
        @(negedge c_clk);
        test_reset();
        test_all_four();
        test_add();
        test_port2_bounds();
        test_port3_ops();
        test_ptr_priority();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/calc_arb.md
CALC_ARB -- requirements
Module: calc_arb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width (only 32 is supported).
REQ-002 SHALL have port c_clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports reqN_cmd_in (N=1..4)  input  [0:3]  requester command.
REQ-005 SHALL have ports reqN_data_in (N=1..4)  input  [0:31]  operand 1 in the command cycle, operand 2 in the following cycle.
REQ-006 SHALL have ports out_respN (N=1..4)  output  [0:1]  response code.
REQ-007 SHALL have ports out_dataN (N=1..4)  output  [0:31]  result.

Function
REQ-008 SHALL share one ALU among four requester ports through a round-robin arbiter.
REQ-009 SHALL decode commands as follows: 0 no-op; 1 add; 2 subtract; 5 shift left; 6 shift right; all other codes invalid.
REQ-010 SHALL run a 3-state FSM per port: IDLE, OP2, PEND.
- IDLE -> OP2 on a non-zero cmd, capturing cmd and operand 1.
- OP2 -> PEND unconditionally, capturing operand 2.
- PEND -> IDLE on grant.
REQ-011 SHALL ignore a port's cmd_in while that port is in OP2 or PEND; one outstanding request per port.
REQ-012 SHALL issue at most one grant per cycle, to the first PEND port at or after the priority pointer, in order 1,2,3,4 with wrap.
REQ-013 SHALL move the priority pointer, after a grant to port k, to port k+1, wrapping 4 -> 1; the pointer SHALL NOT change in cycles without a grant.
REQ-014 SHALL register the ALU result and drive the granted port's out_resp/out_data for exactly one cycle, in the cycle after the grant; all other ports SHALL drive 0/0 in that cycle.
REQ-015 SHALL give a minimum latency of 3 cycles: cmd at edge T, op2 at T+1, grant at T+2, response valid at T+3.
REQ-016 SHALL compute add as unsigned 32-bit; a carry-out SHALL give resp 2, data 0.
REQ-017 SHALL compute subtract as op1 - op2 unsigned; op2 > op1 SHALL give resp 2, data 0.
REQ-018 SHALL shift op1 by op2[27:31] (5 LSBs), zero-filled, always resp 1.
REQ-019 SHALL return resp 2, data 0 for an invalid command.
REQ-020 SHALL return resp 1 with the result on success.
REQ-021 SHALL allow a port to capture a new cmd in the cycle its response is driven, since the port is back in IDLE.
REQ-022 SHALL give all four ports in PEND simultaneously responses on four consecutive cycles in pointer order.

Reset
REQ-023 SHALL, while reset_n is low at a clock edge, force all port FSMs to IDLE, the priority pointer to port 1, and all out_resp/out_data to 0.
REQ-024 SHALL discard requests in flight at reset with no response; the first command is accepted in the first cycle after reset_n is sampled high.

Structure
REQ-025 SHALL place command codes (NOP/ADD/SUB/SHL/SHR), response codes (NONE=0/OK=1/ERR=2) and FSM state encodings in shared package calc_pkg.
REQ-026 SHALL contain the ALU in sub-module calc_alu (combinational: cmd, op1, op2 -> resp, data); the pipeline register stays in calc_arb.

Verification
REQ-027 SHALL cover: port1 add 0x00000001 + 0x01FFFFFF -> port1 resp 1, data 0x02000000 at T+3; other ports 0.
REQ-028 SHALL cover: port2 add 0xFFFFFFFF + 0x00000001 -> resp 2, data 0; port2 sub 0x00000001 - 0x0000000F -> resp 2, data 0.
REQ-029 SHALL cover: port3 cmd 3 and cmd 4 with op 0x00000001 -> resp 2 each; port3 shl 0x00000001 by 0x00000004 -> resp 1, data 0x00000010.
REQ-030 SHALL cover: all four ports issue add 0x00000005 + N in the same cycle -> resps on ports 1,2,3,4 at T+3..T+6, data 6,7,8,9; immediate repeat served 1,2,3,4 again.
REQ-031 SHALL cover: port4 pending, port1 requesting, pointer at 4 -> port4 served before port1.
REQ-032 SHALL cover: reset_n low for one cycle while port1 is in PEND -> no port1 response, all outputs 0, next request from port2 served at T+3.
